srff_bank_arbiter: RTL and testbench

- Shares a bank of `NBITS` SR flip-flops between `NREQ` requesters.
- Each requester asks to set, clear or toggle one bit through a valid/ready handshake.
- A round-robin arbiter grants one request per cycle. A registered command stage then drives the flip-flop S/R inputs, and it never drives S=R=1.
- Sits between control agents and the SR flip-flop bank. The bank's contents are exported as `q`.

---
 rtl/srff_pkg.sv | 23 ++
 rtl/SR_ff.sv | 21 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/srff_bank_arbiter.sv | 107 ++++++++++
 tb/tb_srff_bank_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/srff_pkg.sv
// srff_pkg: op encoding and one-hot helper shared by
// the SR flip-flop bank arbiter and its bench.
package srff_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_CLR = 2'd1,
    OP_SET = 2'd2,
    OP_TGL = 2'd3
  } op_e;

  localparam int MAX_IDXW  = 8;
  localparam int MAX_NBITS = 1 << MAX_IDXW;

  // Widest supported bank; callers size-cast down to NBITS.
  function automatic logic [MAX_NBITS-1:0] onehot(
    input logic [MAX_IDXW-1:0] idx
  );
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/SR_ff.sv
// SR_ff: single set/reset flip-flop cell, S dominant,
// cleared by the active-low asynchronous reset.
module SR_ff (
  input  logic s,
  input  logic r,
  input  logic clk,
  input  logic rst,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (s) begin
      q <= 1'b1;
    end else if (r) begin
      q <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting at ptr; ptr moves
// past the winner whenever advance is high.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_d;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] pick;

  // Rotate so ptr sits at bit 0, take lowest set bit, rotate back.
  always_comb begin
    rot  = NREQ'({req, req} >> ptr_q);
    pick = rot & (~rot + NREQ'(1));
    gnt  = NREQ'(({pick, pick} << ptr_q) >> NREQ);
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) win = PW'(i);
    end
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/srff_bank_arbiter.sv
// srff_bank_arbiter: round-robin shared access to a bank of
// SR flip-flops through a registered S/R command stage.
module srff_bank_arbiter
  import srff_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = $clog2(NBITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 clr_all,
  output logic [NBITS-1:0]     q,
  output logic                 busy
);

  logic [NREQ-1:0]  req_eff;
  logic [NREQ-1:0]  gnt;
  logic             xfer;
  op_e              sel_op;
  logic [IDXW-1:0]  sel_idx;
  logic             in_range;
  logic [NBITS-1:0] oh;
  logic [NBITS-1:0] q_next;
  logic [NBITS-1:0] s_vec_d;
  logic [NBITS-1:0] r_vec_d;
  logic [NBITS-1:0] s_vec_q;
  logic [NBITS-1:0] r_vec_q;

  // Nothing is granted in reset or while the bank is being wiped.
  assign req_eff = req_valid & {NREQ{rst & ~clr_all}};

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_eff),
    .advance(xfer),
    .gnt    (gnt)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    sel_op  = OP_NOP;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_op  = op_e'(req_op[2*i +: 2]);
        sel_idx = req_idx[IDXW*i +: IDXW];
      end
    end
  end

  assign in_range = 32'(sel_idx) < 32'(NBITS);
  assign oh       = NBITS'(onehot(MAX_IDXW'(sel_idx)));

  // Bank value once the held command lands; toggles resolve here.
  assign q_next = (q | s_vec_q) & ~r_vec_q;

  always_comb begin
    s_vec_d = '0;
    r_vec_d = '0;
    if (clr_all) begin
      r_vec_d = '1;
    end else if (xfer && in_range) begin
      unique case (sel_op)
        OP_SET: s_vec_d = oh;
        OP_CLR: r_vec_d = oh;
        OP_TGL: begin
          if (|(q_next & oh)) r_vec_d = oh;
          else                s_vec_d = oh;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_vec_q <= '0;
      r_vec_q <= '0;
    end else begin
      s_vec_q <= s_vec_d;
      r_vec_q <= r_vec_d;
    end
  end

  for (genvar b = 0; b < NBITS; b++) begin : g_bank
    SR_ff u_ff (
      .s  (s_vec_q[b]),
      .r  (r_vec_q[b]),
      .clk(clk),
      .rst(rst),
      .q  (q[b])
    );
  end

  assign busy = |(s_vec_q | r_vec_q);

endmodule

// File: tb/tb_srff_bank_arbiter.sv
// tb_srff_bank_arbiter: directed stimulus, per-cycle compare
// against a bit-array model, plus literal spot checks.
module tb_srff_bank_arbiter;
  import srff_pkg::*;

  logic        clk;
  logic        rst;
  logic        clr_all;
  logic [3:0]  valid;
  logic [7:0]  op;
  logic [11:0] idx;
  logic [3:0]  req_ready;
  logic [7:0]  q;
  logic        busy;

  logic [3:0]  valid6;
  logic [7:0]  op6;
  logic [11:0] idx6;
  logic [3:0]  ready6;
  logic [5:0]  q6;
  logic        busy6;

  int n_tests = 0;
  int n_fail  = 0;

  srff_bank_arbiter #(.NREQ(4), .NBITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(valid),
    .req_op   (op),
    .req_idx  (idx),
    .req_ready(req_ready),
    .clr_all  (clr_all),
    .q        (q),
    .busy     (busy)
  );

  srff_bank_arbiter #(.NREQ(4), .NBITS(6)) dut6 (
    .clk      (clk),
    .rst      (rst),
    .req_valid(valid6),
    .req_op   (op6),
    .req_idx  (idx6),
    .req_ready(ready6),
    .clr_all  (1'b0),
    .q        (q6),
    .busy     (busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: L is the logical bank after every accepted op;
  // the visible bank trails it by one edge.
  logic [7:0] L     = '0;
  logic [7:0] mq    = '0;
  logic       mbusy = 1'b0;
  int         mptr  = 0;

  function automatic int first_valid();
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (mptr + k) % 4;
      if (valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    if (!rst || clr_all) return 4'b0;
    g = first_valid();
    if (g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      L     = '0;
      mq    = '0;
      mbusy = 1'b0;
      mptr  = 0;
    end else begin
      int         g;
      int         x;
      logic [1:0] o;
      logic       nb;
      g  = first_valid();
      nb = 1'b0;
      mq = L;
      if (clr_all) begin
        L  = '0;
        nb = 1'b1;
      end else if (g >= 0) begin
        o = op[2*g +: 2];
        x = int'(idx[3*g +: 3]);
        if (x < 8 && o != OP_NOP) begin
          nb = 1'b1;
          case (o)
            OP_CLR:  L[x] = 1'b0;
            OP_SET:  L[x] = 1'b1;
            default: L[x] = ~L[x];
          endcase
        end
        mptr = (g + 1) % 4;
      end
      mbusy = nb;
    end
  end

  always @(negedge clk) begin
    chk("ready", 32'(req_ready), 32'(exp_ready()));
    chk("q", 32'(q), 32'(mq));
    chk("busy", 32'(busy), 32'(mbusy));
    chk("s_and_r", 32'(dut.s_vec_q & dut.r_vec_q), 32'd0);
    chk("s_and_r6", 32'(dut6.s_vec_q & dut6.r_vec_q), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [1:0] o,
                         input logic [2:0] x);
    valid[i]       = 1'b1;
    op[2*i +: 2]   = o;
    idx[3*i +: 3]  = x;
  endtask

  initial begin
    rst = 1'b0; clr_all = 1'b0;
    valid = 4'hF; op = '0; idx = '0;
    valid6 = '0; op6 = '0; idx6 = '0;

    tick; neg;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    tick; valid = '0; rst = 1'b1;

    // reset then set
    tick;
    set_req(0, OP_SET, 3'd3);
    neg; chk("t1_ready", 32'(req_ready), 32'h1);
    tick; valid[0] = 1'b0;
    neg;
    chk("t1_busy_on", 32'(busy), 32'h1);
    chk("t1_q_wait", 32'(q), 32'h0);
    tick; neg;
    chk("t1_q", 32'(q), 32'h08);
    chk("t1_busy_off", 32'(busy), 32'h0);

    // contention from ptr=0
    tick; rst = 1'b0;
    tick; rst = 1'b1;
    for (int k = 0; k < 4; k++) set_req(k, OP_SET, 3'(k));
    for (int k = 0; k < 4; k++) begin
      neg; chk("t2_order", 32'(req_ready), 32'(1 << k));
      tick; valid[k] = 1'b0;
    end
    tick; neg; chk("t2_q", 32'(q), 32'h0F);

    // restart with ptr=1
    tick;
    set_req(0, OP_NOP, 3'd0);
    tick;
    set_req(1, OP_NOP, 3'd0);
    neg;
    chk("t2_rr_first", 32'(req_ready), 32'h2);
    chk("t2_nop_busy", 32'(busy), 32'h0);
    tick; valid[1] = 1'b0;
    neg; chk("t2_rr_second", 32'(req_ready), 32'h1);
    tick; valid[0] = 1'b0;

    // back-to-back toggle
    clr_all = 1'b1;
    tick; clr_all = 1'b0;
    tick; neg; chk("t3_q_zero", 32'(q), 32'h0);
    tick;
    set_req(2, OP_TGL, 3'd5);
    tick; tick; valid[2] = 1'b0;
    neg; chk("t3_q_hi", 32'(q), 32'h20);
    tick; neg; chk("t3_q_lo", 32'(q), 32'h00);

    // fill, then clr_all against a pending request
    tick;
    for (int k = 0; k < 8; k++) begin
      set_req(0, OP_SET, 3'(k));
      tick;
    end
    valid[0] = 1'b0;
    tick; neg; chk("t4_full", 32'(q), 32'hFF);
    tick;
    set_req(1, OP_CLR, 3'd4);
    clr_all = 1'b1;
    neg; chk("t4_stall", 32'(req_ready), 32'h0);
    tick; clr_all = 1'b0;
    neg;
    chk("t4_gnt_after", 32'(req_ready), 32'h2);
    chk("t4_q_hold", 32'(q), 32'hFF);
    tick; valid[1] = 1'b0;
    neg; chk("t4_q_clr", 32'(q), 32'h00);
    tick; neg; chk("t4_q_stay", 32'(q), 32'h00);

    // reset mid-operation
    tick;
    set_req(3, OP_SET, 3'd0);
    tick;
    set_req(3, OP_SET, 3'd7);
    tick; valid[3] = 1'b0;
    neg;
    chk("t5_q_pre", 32'(q), 32'h01);
    chk("t5_busy_pre", 32'(busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("t5_q_rst", 32'(q), 32'h0);
    chk("t5_busy_rst", 32'(busy), 32'h0);
    tick; rst = 1'b1;
    tick; neg;
    chk("t5_q_after", 32'(q), 32'h0);
    chk("t5_busy_after", 32'(busy), 32'h0);

    // out-of-range index on the 6-bit bank
    tick;
    valid6[0] = 1'b1; op6[1:0] = OP_SET; idx6[2:0] = 3'd1;
    neg; chk("t6_ready_in", 32'(ready6), 32'h1);
    tick; valid6[0] = 1'b0;
    tick;
    valid6[0] = 1'b1; idx6[2:0] = 3'd7;
    neg;
    chk("t6_q_pre", 32'(q6), 32'h02);
    chk("t6_ready_oor", 32'(ready6), 32'h1);
    tick; valid6[0] = 1'b0;
    neg; chk("t6_busy", 32'(busy6), 32'h0);
    tick; neg;
    chk("t6_q", 32'(q6), 32'h02);
    chk("t6_busy2", 32'(busy6), 32'h0);

    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
